// File: rtl/ddr3_wr_burst_master.sv
// DDR3 write-command master: drains one BRAM line-buffer rank into DDR3, packing
// DDR_DW/BUF_DW beats per command and rotating banks per frame. Optional DDR3_WR_TAIL_MASK_EN.
module ddr3_wr_burst_master #(
  parameter int BUF_DW      = 64,
  parameter int DDR_DW      = 128,
  parameter int RANK_W      = 2,
  parameter int WORD_CNT_W  = 7,
  parameter int ADDR_STEP   = 8,
  parameter int BANK_BASE   = 1,
  parameter int FRAME_BANKS = 4,
  parameter int BRAM_RD_LAT = 2
) (
  input  logic                                                 i_pclk,
  input  logic                                                 i_rst_n,
  input  logic                                                 i_wr_req,
  input  logic                                                 i_frame_done,
  input  logic [RANK_W-1:0]                                    i_buf_rank,
  input  logic [WORD_CNT_W-1:0]                                i_buf_words,
  input  logic [$clog2(DDR_DW/8)-1:0]                          i_tail_bytes,
  output logic [RANK_W+WORD_CNT_W+$clog2(DDR_DW/BUF_DW)-1:0]   o_buf_addr,
  output logic                                                 o_buf_ce,
  input  logic [BUF_DW-1:0]                                    i_buf_rd_data,
  output logic [2:0]                                           o_ddr3_cmd,
  output logic                                                 o_ddr3_cmd_en,
  output logic [27:0]                                          o_ddr3_addr,
  output logic [DDR_DW-1:0]                                    o_ddr3_wr_data,
  output logic                                                 o_ddr3_wr_data_en,
  output logic                                                 o_ddr3_wr_data_end,
  output logic [DDR_DW/8-1:0]                                  o_ddr3_wr_mask,
  input  logic                                                 i_ddr3_cmd_ready,
  input  logic                                                 i_ddr3_wr_data_rdy,
  output logic                                                 o_wr_done,
  output logic                                                 o_busy,
  output logic                                                 o_req_overrun,
  output logic [2:0]                                           o_last_frame_bank,
  output logic [23:0]                                          o_last_frame_len
);
  localparam int R     = DDR_DW / BUF_DW;
  localparam int LOG_R = $clog2(R);
  localparam int BA_W  = WORD_CNT_W + LOG_R;
  localparam int CW    = LOG_R + 1;
  localparam int MW    = DDR_DW / 8;
  localparam logic [2:0] BANK_FIRST = 3'(BANK_BASE);
  localparam logic [2:0] BANK_LAST  = 3'(BANK_BASE + FRAME_BANKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    req_prev_q, req_prev_d, frm_prev_q, frm_prev_d;
  logic                    req_pend_q, req_pend_d, frm_pend_q, frm_pend_d;
  logic                    overrun_q, overrun_d;
  logic [RANK_W-1:0]       rank_q, rank_d;
  logic [WORD_CNT_W-1:0]   words_q, words_d;
  logic [BA_W-1:0]         beat_addr_q, beat_addr_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [BRAM_RD_LAT-1:0]  vld_pipe_q, vld_pipe_d;
  logic [DDR_DW-1:0]       data_q, data_d;
  logic [2:0]              bank_q, bank_d, last_bank_q, last_bank_d;
  logic [23:0]             row_col_q, row_col_d, last_len_q, last_len_d;
  logic                    req_edge, frm_edge, req_take, frm_take, buf_ce, fire, rd_valid;

  assign req_edge = i_wr_req & ~req_prev_q;
  assign frm_edge = i_frame_done & ~frm_prev_q;
  assign buf_ce   = (state_q == S_FETCH) && (rd_cnt_q < CW'(R));
  assign fire     = (state_q == S_ISSUE) && i_ddr3_cmd_ready && i_ddr3_wr_data_rdy;
  // vld_pipe tracks each issued read until its data returns from the BRAM
  assign rd_valid = vld_pipe_q[BRAM_RD_LAT-1];

  always_comb begin
    state_d     = state_q;
    req_prev_d  = i_wr_req;
    frm_prev_d  = i_frame_done;
    rank_d      = rank_q;
    words_d     = words_q;
    beat_addr_d = beat_addr_q;
    rd_cnt_d    = rd_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    data_d      = data_q;
    bank_d      = bank_q;
    row_col_d   = row_col_q;
    last_bank_d = last_bank_q;
    last_len_d  = last_len_q;
    req_take    = 1'b0;
    frm_take    = 1'b0;
    vld_pipe_d  = (vld_pipe_q << 1) | BRAM_RD_LAT'(buf_ce);
    unique case (state_q)
      S_IDLE: begin
        if (req_pend_q) begin
          req_take    = 1'b1;
          rank_d      = i_buf_rank;
          words_d     = i_buf_words;
          beat_addr_d = '0;
          rd_cnt_d    = '0;
          cap_cnt_d   = '0;
          state_d     = (i_buf_words == '0) ? S_DONE : S_FETCH;
        end else if (frm_pend_q) begin
          frm_take    = 1'b1;
          last_bank_d = bank_q;
          last_len_d  = row_col_q;
          row_col_d   = '0;
          bank_d      = (bank_q == BANK_LAST) ? BANK_FIRST : bank_q + 3'd1;
        end
      end
      S_FETCH: begin
        if (buf_ce) begin
          beat_addr_d = beat_addr_q + BA_W'(1);
          rd_cnt_d    = rd_cnt_q + CW'(1);
        end
        if (rd_valid) begin
          data_d[cap_cnt_q*BUF_DW +: BUF_DW] = i_buf_rd_data;
          cap_cnt_d = cap_cnt_q + CW'(1);
          if (cap_cnt_q == CW'(R - 1)) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          row_col_d = row_col_q + 24'(ADDR_STEP);
          words_d   = words_q - WORD_CNT_W'(1);
          rd_cnt_d  = '0;
          cap_cnt_d = '0;
          state_d   = (words_q == WORD_CNT_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // an edge landing on the consume cycle re-arms the flag instead of being lost
    req_pend_d = req_take ? req_edge : (req_pend_q | req_edge);
    frm_pend_d = frm_take ? frm_edge : (frm_pend_q | frm_edge);
    overrun_d  = req_edge & req_pend_q & ~req_take;
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      req_prev_q  <= 1'b1;
      frm_prev_q  <= 1'b1;
      req_pend_q  <= 1'b0;
      frm_pend_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rank_q      <= '0;
      words_q     <= '0;
      beat_addr_q <= '0;
      rd_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      vld_pipe_q  <= '0;
      data_q      <= '0;
      bank_q      <= BANK_FIRST;
      row_col_q   <= '0;
      last_bank_q <= '0;
      last_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= req_prev_d;
      frm_prev_q  <= frm_prev_d;
      req_pend_q  <= req_pend_d;
      frm_pend_q  <= frm_pend_d;
      overrun_q   <= overrun_d;
      rank_q      <= rank_d;
      words_q     <= words_d;
      beat_addr_q <= beat_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      data_q      <= data_d;
      bank_q      <= bank_d;
      row_col_q   <= row_col_d;
      last_bank_q <= last_bank_d;
      last_len_q  <= last_len_d;
    end
  end

`ifdef DDR3_WR_TAIL_MASK_EN
  logic [$clog2(MW)-1:0] tail_q, tail_d;
  logic [MW-1:0]         tail_bit;

  always_comb begin
    tail_d = tail_q;
    if (state_q == S_IDLE && req_pend_q) tail_d = i_tail_bytes;
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) tail_q <= '0;
    else          tail_q <= tail_d;
  end

  assign tail_bit       = MW'(1) << tail_q;
  assign o_ddr3_wr_mask = (state_q == S_ISSUE && words_q == WORD_CNT_W'(1) && tail_q != '0)
                          ? ~(tail_bit - MW'(1)) : '0;
`else
  logic unused_tail;
  assign unused_tail    = ^i_tail_bytes;
  assign o_ddr3_wr_mask = '0;
`endif

  assign o_buf_ce           = buf_ce;
  assign o_buf_addr         = buf_ce ? {rank_q, beat_addr_q} : '0;
  assign o_ddr3_cmd         = 3'd0;
  assign o_ddr3_cmd_en      = fire;
  assign o_ddr3_wr_data_en  = fire;
  assign o_ddr3_wr_data_end = fire;
  assign o_ddr3_addr        = (state_q == S_ISSUE) ? {1'b0, bank_q, row_col_q} : '0;
  assign o_ddr3_wr_data     = (state_q == S_ISSUE) ? data_q : '0;
  assign o_wr_done          = (state_q == S_DONE);
  assign o_busy             = (state_q != S_IDLE);
  assign o_req_overrun      = overrun_q;
  assign o_last_frame_bank  = last_bank_q;
  assign o_last_frame_len   = last_len_q;
endmodule
